iprf_pend_scoreboard: RTL and testbench

- Holds one pending bit per integer physical register and is the source of the psrc1_pend/psrc2_pend bits in the rename packet.
- Rename allocation of a pdst sets the bit. An IPRF write at ro0 clears it.
- Rename looks up both sources each cycle. The result is the pending state that downstream pend watching then refines.
- Sits in the rename stage, beside the free list and the map table.

---
 rtl/iprf_pend_scoreboard_pkg.sv | 15 +
 rtl/pend_popcnt.sv | 18 +
 rtl/iprf_pend_scoreboard.sv | 94 +++++++++
 tb/tb_iprf_pend_scoreboard.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iprf_pend_scoreboard_pkg.sv
// Common IPRF definitions shared by the rename-stage pending scoreboard.
// Holds the register-file sizing, the physical register index type and the write packet type.
package iprf_pend_scoreboard_pkg;

    localparam int IPRF_NUM_ENTS   = 64;
    localparam int IPRF_NUM_WRITES = 4;
    localparam int IPRF_PREG_W     = $clog2(IPRF_NUM_ENTS);

    typedef logic [IPRF_PREG_W-1:0] t_preg_idx;

    typedef struct packed {
        t_preg_idx pdst;
    } t_prf_wr_pkt;

endpackage

// File: rtl/pend_popcnt.sv
// Parameterized population count of an N-bit vector.
module pend_popcnt #(
    parameter int N = 64,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] cnt
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(vec[i]);
        end
    end

endmodule

// File: rtl/iprf_pend_scoreboard.sv
// Per-preg pending scoreboard feeding psrc1_pend/psrc2_pend of the rename packet.
// Optional macro IPRF_PEND_SB_BYPASS_EN: lookups also clear sources hit by a same-cycle IPRF write.
module iprf_pend_scoreboard
    import iprf_pend_scoreboard_pkg::*;
#(
    parameter int NUM_PREGS = IPRF_NUM_ENTS,
    parameter int NUM_WR    = IPRF_NUM_WRITES,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rn_alloc_en,
    input  logic [PREG_W-1:0] rn_alloc_pdst,
    input  logic [PREG_W-1:0] rn_psrc1,
    input  logic [PREG_W-1:0] rn_psrc2,
    output logic              rn_psrc1_pend,
    output logic              rn_psrc2_pend,
    input  logic [NUM_WR-1:0] iprf_wr_en_ro0,
    input  t_prf_wr_pkt       iprf_wr_pkt_ro0 [NUM_WR],
    input  logic              flush_en,
    input  logic [NUM_PREGS-1:0] flush_clr_vec,
    output logic [PREG_W:0]   pend_cnt,
    output logic              pend_sat
);

    logic [NUM_PREGS-1:0] pend_q;
    logic [NUM_PREGS-1:0] pend_d;
    logic [NUM_PREGS-1:0] wr_clr;
    logic [NUM_PREGS-1:0] flush_clr;
    logic [PREG_W:0]      cnt_d;
    logic                 sat_d;

    always_comb begin
        wr_clr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (iprf_wr_en_ro0[w]) begin
                wr_clr[iprf_wr_pkt_ro0[w].pdst] = 1'b1;
            end
        end
        flush_clr = flush_en ? flush_clr_vec : '0;

        // Alloc is applied last so it wins over a same-cycle write or flush clear.
        pend_d = pend_q & ~wr_clr & ~flush_clr;
        if (rn_alloc_en) begin
            pend_d[rn_alloc_pdst] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    pend_popcnt #(
        .N (NUM_PREGS),
        .W (PREG_W + 1)
    ) u_popcnt (
        .vec (pend_d),
        .cnt (cnt_d)
    );

    assign sat_d = &pend_d[NUM_PREGS-1:1];

    // NOTE: sequential state uses non-blocking assignments; the whole flop vector resets, it is not a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            pend_cnt <= '0;
            pend_sat <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_cnt <= cnt_d;
            pend_sat <= sat_d;
        end
    end

`ifdef IPRF_PEND_SB_BYPASS_EN
    assign rn_psrc1_pend = pend_q[rn_psrc1] & ~wr_clr[rn_psrc1] & (rn_psrc1 != '0);
    assign rn_psrc2_pend = pend_q[rn_psrc2] & ~wr_clr[rn_psrc2] & (rn_psrc2 != '0);
`else
    assign rn_psrc1_pend = pend_q[rn_psrc1] & (rn_psrc1 != '0);
    assign rn_psrc2_pend = pend_q[rn_psrc2] & (rn_psrc2 != '0);
`endif

    a_alloc_not_zero: assert property (@(posedge clk) disable iff (!reset_n)
        rn_alloc_en |-> rn_alloc_pdst != '0);

    // A pending preg may only be re-allocated when the same cycle's write or flush frees it.
    a_alloc_not_pending: assert property (@(posedge clk) disable iff (!reset_n)
        rn_alloc_en |-> !(pend_q[rn_alloc_pdst] & ~wr_clr[rn_alloc_pdst] & ~flush_clr[rn_alloc_pdst]));

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_chk
        a_wr_to_pending: assert property (@(posedge clk) disable iff (!reset_n)
            iprf_wr_en_ro0[w] |-> (pend_q[iprf_wr_pkt_ro0[w].pdst] ||
                                   (rn_alloc_en && rn_alloc_pdst == iprf_wr_pkt_ro0[w].pdst)));
    end

endmodule

// File: tb/tb_iprf_pend_scoreboard.sv
// Self-checking bench for iprf_pend_scoreboard: behavioural pending-set model plus directed literal checks.
module tb_iprf_pend_scoreboard;
    import iprf_pend_scoreboard_pkg::*;

    localparam int NP = IPRF_NUM_ENTS;
    localparam int NW = IPRF_NUM_WRITES;
    localparam int PW = $clog2(NP);
`ifdef IPRF_PEND_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rn_alloc_en;
    logic [PW-1:0] rn_alloc_pdst;
    logic [PW-1:0] rn_psrc1;
    logic [PW-1:0] rn_psrc2;
    logic          rn_psrc1_pend;
    logic          rn_psrc2_pend;
    logic [NW-1:0] iprf_wr_en_ro0;
    t_prf_wr_pkt   iprf_wr_pkt_ro0 [NW];
    logic          flush_en;
    logic [NP-1:0] flush_clr_vec;
    logic [PW:0]   pend_cnt;
    logic          pend_sat;

    int n_cmp  = 0;
    int n_fail = 0;

    bit model [NP];

    iprf_pend_scoreboard dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rn_alloc_en     (rn_alloc_en),
        .rn_alloc_pdst   (rn_alloc_pdst),
        .rn_psrc1        (rn_psrc1),
        .rn_psrc2        (rn_psrc2),
        .rn_psrc1_pend   (rn_psrc1_pend),
        .rn_psrc2_pend   (rn_psrc2_pend),
        .iprf_wr_en_ro0  (iprf_wr_en_ro0),
        .iprf_wr_pkt_ro0 (iprf_wr_pkt_ro0),
        .flush_en        (flush_en),
        .flush_clr_vec   (flush_clr_vec),
        .pend_cnt        (pend_cnt),
        .pend_sat        (pend_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int p = 0; p < NP; p++) c += int'(model[p]);
        return c;
    endfunction

    function automatic bit written_now(input logic [PW-1:0] p);
        bit hit = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (iprf_wr_en_ro0[w] && iprf_wr_pkt_ro0[w].pdst == p) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic bit model_lookup(input logic [PW-1:0] p);
        if (p == 0) return 1'b0;
        return model[p] & ~(BYPASS & written_now(p));
    endfunction

    // Model of the pending set: writes and flush free pregs, then rename allocation claims one.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NP; p++) model[p] = 1'b0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (iprf_wr_en_ro0[w]) model[iprf_wr_pkt_ro0[w].pdst] = 1'b0;
            end
            if (flush_en) begin
                for (int p = 0; p < NP; p++) begin
                    if (flush_clr_vec[p]) model[p] = 1'b0;
                end
            end
            if (rn_alloc_en) model[rn_alloc_pdst] = 1'b1;
            model[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("cmp_psrc1", 32'(rn_psrc1_pend), 32'(model_lookup(rn_psrc1)));
        check("cmp_psrc2", 32'(rn_psrc2_pend), 32'(model_lookup(rn_psrc2)));
        check("cmp_cnt", 32'(pend_cnt), 32'(model_cnt()));
        check("cmp_sat", 32'(pend_sat), 32'(model_cnt() == NP - 1 && !model[0]));
    end

    task automatic idle();
        rn_alloc_en    = 1'b0;
        rn_alloc_pdst  = PW'(1);
        iprf_wr_en_ro0 = '0;
        for (int w = 0; w < NW; w++) iprf_wr_pkt_ro0[w] = '0;
        flush_en       = 1'b0;
        flush_clr_vec  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic alloc(input int p);
        rn_alloc_en   = 1'b1;
        rn_alloc_pdst = PW'(p);
        tick();
    endtask

    task automatic wr(input int port, input int p);
        iprf_wr_en_ro0[port]       = 1'b1;
        iprf_wr_pkt_ro0[port].pdst = PW'(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        rn_psrc1 = PW'(5);
        rn_psrc2 = PW'(63);
        idle();

        // Reset held for three cycles, then released.
        repeat (3) tick();
        check("rst_cnt", 32'(pend_cnt), 0);
        check("rst_sat", 32'(pend_sat), 0);
        reset_n = 1'b1;
        tick();
        check("rst_psrc5", 32'(rn_psrc1_pend), 0);
        check("rst_psrc63", 32'(rn_psrc2_pend), 0);

        // Alloc 12, visible from the next cycle, cleared by a write three cycles later.
        rn_psrc1 = PW'(12);
        rn_alloc_en   = 1'b1;
        rn_alloc_pdst = PW'(12);
        #1;
        check("alloc_same_cyc", 32'(rn_psrc1_pend), 0);
        tick();
        check("alloc_c1", 32'(rn_psrc1_pend), 1);
        check("alloc_cnt1", 32'(pend_cnt), 1);
        tick();
        tick();
        check("alloc_c3", 32'(rn_psrc1_pend), 1);
        wr(0, 12);
        tick();
        check("wr_c4", 32'(rn_psrc1_pend), 0);
        check("wr_cnt0", 32'(pend_cnt), 0);

        // Same-cycle write and lookup of preg 20.
        rn_psrc2 = PW'(20);
        alloc(20);
        wr(0, 20);
        #1;
        check("byp_lookup", 32'(rn_psrc2_pend), BYPASS ? 0 : 1);
        tick();
        check("byp_after", 32'(rn_psrc2_pend), 0);

        // Collision on preg 7: write, flush clear and alloc together; alloc wins.
        rn_psrc1 = PW'(7);
        alloc(7);
        check("coll_cnt_before", 32'(pend_cnt), 1);
        wr(1, 7);
        flush_en         = 1'b1;
        flush_clr_vec[7] = 1'b1;
        rn_alloc_en      = 1'b1;
        rn_alloc_pdst    = PW'(7);
        tick();
        check("coll_pend7", 32'(rn_psrc1_pend), 1);
        check("coll_cnt", 32'(pend_cnt), 1);
        wr(0, 7);
        tick();

        // Flush of pregs 2 and 40 with 1,2,3,40 pending.
        alloc(1);
        alloc(2);
        alloc(3);
        alloc(40);
        check("flush_cnt4", 32'(pend_cnt), 4);
        flush_en          = 1'b1;
        flush_clr_vec[2]  = 1'b1;
        flush_clr_vec[40] = 1'b1;
        tick();
        check("flush_cnt2", 32'(pend_cnt), 2);
        rn_psrc1 = PW'(1);
        rn_psrc2 = PW'(2);
        #1;
        check("flush_keep1", 32'(rn_psrc1_pend), 1);
        check("flush_clr2", 32'(rn_psrc2_pend), 0);
        rn_psrc1 = PW'(3);
        rn_psrc2 = PW'(40);
        #1;
        check("flush_keep3", 32'(rn_psrc1_pend), 1);
        check("flush_clr40", 32'(rn_psrc2_pend), 0);
        flush_en = 1'b1;
        tick();
        check("flush_noop", 32'(pend_cnt), 2);

        // Drain with several ports, two of them on the same pdst.
        wr(0, 3);
        wr(2, 1);
        wr(3, 1);
        tick();
        check("drain_cnt", 32'(pend_cnt), 0);

        // Saturation: allocate 1..63, then one write.
        rn_psrc1 = PW'(0);
        rn_psrc2 = PW'(9);
        for (int p = 1; p < NP; p++) begin
            alloc(p);
            if (p == NP - 2) begin
                check("sat_cnt62", 32'(pend_cnt), 62);
                check("sat_pre", 32'(pend_sat), 0);
            end
        end
        check("sat_cnt63", 32'(pend_cnt), 63);
        check("sat_set", 32'(pend_sat), 1);
        check("sat_psrc0", 32'(rn_psrc1_pend), 0);
        wr(0, 9);
        tick();
        check("unsat_cnt", 32'(pend_cnt), 62);
        check("unsat_sat", 32'(pend_sat), 0);
        check("unsat_psrc9", 32'(rn_psrc2_pend), 0);

        // Asynchronous reset in mid-operation, away from any clock edge.
        rn_psrc2 = PW'(10);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(pend_cnt), 0);
        check("mid_rst_sat", 32'(pend_sat), 0);
        check("mid_rst_psrc10", 32'(rn_psrc2_pend), 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
